// File: rtl/uart_tx_fifo.sv
// Byte UART transmitter (8N1) fed by a circular-buffer FIFO.
// Busy_o flags a full FIFO, Empty_o flags a fully drained block, and Overflow_o latches any dropped write.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] Data_i,
  input  logic       Trans_i,
  output logic       Busy_o,
  output logic       Empty_o,
  output logic       Tx_o,
  output logic       Overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push_c;
  logic pop_c;
  logic bit_end_c;

  assign Busy_o     = (count_q == NW'(FIFO_DEPTH));
  assign Empty_o    = (count_q == '0) && (state_q == S_IDLE);
  assign Tx_o       = tx_q;
  assign Overflow_o = ovf_q;

  // A push is decided on the current Busy_o only; a same-cycle pop does not make room.
  assign push_c    = Trans_i & ~Busy_o;
  assign bit_end_c = (bcnt_q == CW'(CLK_DIV - 1));

  // FIFO pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (Trans_i & Busy_o);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serialiser: start bit, 8 data bits LSB first, stop bit; reloads from the FIFO in STOP.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + CW'(1);
    bidx_d  = bidx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          bcnt_d  = '0;
          tx_d    = shift_q[0];
          bidx_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bidx_d  = bidx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          bcnt_d = '0;
          if (count_q != '0) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bcnt_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bcnt_q   <= bcnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= Data_i;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=16.
// A line receiver decodes Tx_o into a byte queue; each test task checks its own expectations.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] Data_i;
  logic       Trans_i;
  logic       Busy_o;
  logic       Empty_o;
  logic       Tx_o;
  logic       Overflow_o;

  int n_checks;
  int n_pass;
  int cyc;

  // Line receiver state
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         rx_ferr;
  bit         rx_busy;
  int         rx_cnt;
  logic [7:0] rx_byte;
  int         max_cnt;

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .Data_i    (Data_i),
    .Trans_i   (Trans_i),
    .Busy_o    (Busy_o),
    .Empty_o   (Empty_o),
    .Tx_o      (Tx_o),
    .Overflow_o(Overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Decode frames: samples at bit centres (4 negedges per bit), start-bit and stop-bit checked.
  always @(negedge clk) begin
    if (!rstn) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (Tx_o === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 2 && Tx_o !== 1'b0) rx_ferr = rx_ferr + 1;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
        rx_byte[3'((rx_cnt - 6) / 4)] = Tx_o;
      if (rx_cnt == 38) begin
        if (Tx_o !== 1'b1) rx_ferr = rx_ferr + 1;
        rx_q.push_back(rx_byte);
      end
      if (rx_cnt == 39) rx_busy = 1'b0;
    end
    if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
  end

  task automatic apply_reset();
    @(negedge clk);
    Trans_i = 1'b0;
    Data_i  = 8'h00;
    rstn    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rx_q.delete();
    rx_start_q.delete();
    rx_ferr = 0;
    max_cnt = 0;
  endtask

  task automatic wait_empty(input int limit, input string name);
    int k;
    k = 0;
    while (Empty_o !== 1'b1 && k < limit) begin
      @(negedge clk);
      k = k + 1;
    end
    n_checks = n_checks + 1;
    if (Empty_o === 1'b1) n_pass = n_pass + 1;
    else $display("FAIL %s_drain_timeout: Empty_o=%b after %0d cycles, required 1", name, Empty_o, k);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks = n_checks + 4;
    if (Tx_o !== 1'b1) $display("FAIL reset_tx: got %b required 1", Tx_o); else n_pass = n_pass + 1;
    if (Busy_o !== 1'b0) $display("FAIL reset_busy: got %b required 0", Busy_o); else n_pass = n_pass + 1;
    if (Empty_o !== 1'b1) $display("FAIL reset_empty: got %b required 1", Empty_o); else n_pass = n_pass + 1;
    if (Overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b required 0", Overflow_o); else n_pass = n_pass + 1;
  endtask

  task automatic test_single();
    logic [9:0] lvl;
    int         bad;
    lvl = 10'b11_0100_1010;  // 0xA5 framed: index 0 = start bit, index 9 = stop bit
    apply_reset();
    @(negedge clk);
    Trans_i = 1'b1;
    Data_i  = 8'hA5;
    @(negedge clk);
    Trans_i = 1'b0;
    n_checks = n_checks + 2;
    if (Tx_o !== 1'b1) $display("FAIL single_latency_tx: got %b required 1", Tx_o); else n_pass = n_pass + 1;
    if (Empty_o !== 1'b0) $display("FAIL single_empty_fall: got %b required 0", Empty_o); else n_pass = n_pass + 1;
    bad = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (Tx_o !== lvl[s / 4]) begin
        bad = bad + 1;
        $display("FAIL single_wave_s%0d: got %b required %b", s, Tx_o, lvl[s / 4]);
      end
    end
    n_checks = n_checks + 1;
    if (bad == 0) n_pass = n_pass + 1;
    n_checks = n_checks + 1;
    if (Empty_o !== 1'b0) $display("FAIL single_empty_in_stop: got %b required 0", Empty_o); else n_pass = n_pass + 1;
    @(negedge clk);
    n_checks = n_checks + 3;
    if (Empty_o !== 1'b1) $display("FAIL single_empty_rise: got %b required 1", Empty_o); else n_pass = n_pass + 1;
    if (Tx_o !== 1'b1) $display("FAIL single_idle_tx: got %b required 1", Tx_o); else n_pass = n_pass + 1;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5)
      $display("FAIL single_rx: got %0d bytes first %h required 1 byte a5", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else n_pass = n_pass + 1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    Trans_i = 1'b1;
    Data_i  = 8'h00;
    @(negedge clk);
    Data_i  = 8'hFF;
    @(negedge clk);
    Trans_i = 1'b0;
    wait_empty(200, "b2b");
    n_checks = n_checks + 4;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF)
      $display("FAIL b2b_rx: got %0d bytes required 2 bytes 00 ff", rx_q.size());
    else n_pass = n_pass + 1;
    if (rx_start_q.size() != 2 || (rx_start_q[1] - rx_start_q[0]) != 40)
      $display("FAIL b2b_gap: got %0d starts spacing %0d required 2 starts spacing 40", rx_start_q.size(),
               (rx_start_q.size() == 2) ? rx_start_q[1] - rx_start_q[0] : -1);
    else n_pass = n_pass + 1;
    if (max_cnt != 1) $display("FAIL b2b_count_peak: got %0d required 1", max_cnt); else n_pass = n_pass + 1;
    if (rx_ferr != 0) $display("FAIL b2b_framing: got %0d errors required 0", rx_ferr); else n_pass = n_pass + 1;
  endtask

  task automatic test_fill_overflow_drain();
    logic [7:0] exp_q[$];
    int         k;
    int         bad;
    apply_reset();
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 18) begin
        n_checks = n_checks + 2;
        if (Busy_o !== 1'b1) $display("FAIL fill_busy17: got %b required 1", Busy_o); else n_pass = n_pass + 1;
        if (Overflow_o !== 1'b0) $display("FAIL fill_ovf17: got %b required 0", Overflow_o); else n_pass = n_pass + 1;
      end
      Trans_i = 1'b1;
      Data_i  = 8'(i);
    end
    @(negedge clk);
    n_checks = n_checks + 2;
    if (Overflow_o !== 1'b1) $display("FAIL fill_ovf18: got %b required 1", Overflow_o); else n_pass = n_pass + 1;
    if (Busy_o !== 1'b1) $display("FAIL fill_busy18: got %b required 1", Busy_o); else n_pass = n_pass + 1;
    Data_i = 8'hEE;
    // Keep writing while full; Busy_o drops one cycle after the 0x01 frame ends and 0x02 is popped.
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k = k + 1;
      if (Busy_o === 1'b0) break;
    end
    n_checks = n_checks + 1;
    if (k != 24) $display("FAIL drain_busy_fall: got cycle %0d required 24", k); else n_pass = n_pass + 1;
    @(negedge clk);
    Trans_i = 1'b0;
    n_checks = n_checks + 1;
    if (Busy_o !== 1'b1) $display("FAIL drain_refill_busy: got %b required 1", Busy_o); else n_pass = n_pass + 1;
    wait_empty(2000, "fill");
    for (int i = 1; i <= 17; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hEE);
    bad = 0;
    n_checks = n_checks + 1;
    if (rx_q.size() != exp_q.size()) begin
      $display("FAIL fill_rx_count: got %0d required %0d", rx_q.size(), exp_q.size());
    end else begin
      n_pass = n_pass + 1;
      for (int i = 0; i < exp_q.size(); i++)
        if (rx_q[i] !== exp_q[i]) begin
          bad = bad + 1;
          $display("FAIL fill_rx_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
        end
    end
    n_checks = n_checks + 3;
    if (bad == 0 && rx_q.size() == exp_q.size()) n_pass = n_pass + 1;
    else $display("FAIL fill_rx_order: %0d wrong bytes", bad);
    if (Overflow_o !== 1'b1) $display("FAIL fill_ovf_sticky: got %b required 1", Overflow_o); else n_pass = n_pass + 1;
    if (rx_ferr != 0) $display("FAIL fill_framing: got %0d errors required 0", rx_ferr); else n_pass = n_pass + 1;
  endtask

  task automatic test_pointer_wrap();
    int sent;
    int k;
    int bad;
    apply_reset();
    sent = 0;
    k = 0;
    while (sent < 40 && k < 5000) begin
      @(negedge clk);
      k = k + 1;
      if (Busy_o === 1'b0) begin
        Trans_i = 1'b1;
        Data_i  = 8'(sent);
        sent = sent + 1;
      end else begin
        Trans_i = 1'b0;
      end
    end
    @(negedge clk);
    Trans_i = 1'b0;
    n_checks = n_checks + 1;
    if (sent != 40) $display("FAIL wrap_send_timeout: sent %0d required 40", sent); else n_pass = n_pass + 1;
    wait_empty(3000, "wrap");
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (i >= rx_q.size() || rx_q[i] !== 8'(i)) bad = bad + 1;
    n_checks = n_checks + 4;
    if (rx_q.size() != 40) $display("FAIL wrap_rx_count: got %0d required 40", rx_q.size()); else n_pass = n_pass + 1;
    if (bad != 0) $display("FAIL wrap_rx_order: got %0d wrong bytes required 0", bad); else n_pass = n_pass + 1;
    if (Overflow_o !== 1'b0) $display("FAIL wrap_ovf: got %b required 0", Overflow_o); else n_pass = n_pass + 1;
    if (rx_ferr != 0) $display("FAIL wrap_framing: got %0d errors required 0", rx_ferr); else n_pass = n_pass + 1;
  endtask

  task automatic test_reset_mid_frame();
    int k;
    int low;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Trans_i = 1'b1;
      Data_i  = 8'h30 + 8'(i);
    end
    @(negedge clk);
    Trans_i = 1'b0;
    // Advance to the second sample of data bit 3 of the 0x30 frame (line low there).
    k = 0;
    while ((rx_start_q.size() == 0 || cyc != rx_start_q[0] + 17) && k < 200) begin
      @(negedge clk);
      k = k + 1;
    end
    n_checks = n_checks + 1;
    if (Tx_o !== 1'b0) $display("FAIL rst_mid_pre_tx: got %b required 0", Tx_o); else n_pass = n_pass + 1;
    rstn = 1'b0;
    #1;
    n_checks = n_checks + 4;
    if (Tx_o !== 1'b1) $display("FAIL rst_mid_tx: got %b required 1", Tx_o); else n_pass = n_pass + 1;
    if (Empty_o !== 1'b1) $display("FAIL rst_mid_empty: got %b required 1", Empty_o); else n_pass = n_pass + 1;
    if (Busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", Busy_o); else n_pass = n_pass + 1;
    if (Overflow_o !== 1'b0) $display("FAIL rst_mid_ovf: got %b required 0", Overflow_o); else n_pass = n_pass + 1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Tx_o !== 1'b1) low = low + 1;
    end
    n_checks = n_checks + 3;
    if (low != 0) $display("FAIL rst_mid_quiet: got %0d low cycles required 0", low); else n_pass = n_pass + 1;
    if (rx_q.size() != 0) $display("FAIL rst_mid_rx: got %0d bytes required 0", rx_q.size()); else n_pass = n_pass + 1;
    if (Empty_o !== 1'b1) $display("FAIL rst_mid_empty_after: got %b required 1", Empty_o); else n_pass = n_pass + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rx_ferr  = 0;
    rx_busy  = 1'b0;
    rx_cnt   = 0;
    rx_byte  = 8'h00;
    max_cnt  = 0;
    rstn     = 1'b0;
    Trans_i  = 1'b0;
    Data_i   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow_drain();
    test_pointer_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
